mmss_countdown_timer: RTL and testbench

//  Parametrised MM:SS countdown timer; successor to the basic cascaded-BCD timer.
//  - Loads all four BCD digits in one cycle, with digit-range checking.
//  - Internal seconds prescaler; start/pause/resume control FSM.
//  - One-shot or auto-reload mode; registered finished pulse plus done level.
//  - Sits between the button/switch front end and the 7-segment display driver.

---
 rtl/mmss_countdown_timer_pkg.sv | 17 +
 rtl/mmss_countdown_timer_digit.sv | 33 +++
 rtl/mmss_countdown_timer.sv | 180 ++++++++++++++++++
 tb/tb_mmss_countdown_timer.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmss_countdown_timer_pkg.sv
// Shared types and constants for the MM:SS countdown timer.
// State encoding plus BCD digit limits.
package mmss_countdown_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int BCD_W = 4;

  localparam logic [BCD_W-1:0] SEC_TENS_MAX = 4'd5;
  localparam logic [BCD_W-1:0] DIGIT_MAX    = 4'd9;

endpackage

// File: rtl/mmss_countdown_timer_digit.sv
// One BCD down-counting digit with parallel load.
// Wraps 0 -> MAX and flags a borrow to the next digit up.
module bcd_down_digit
  import mmss_countdown_timer_pkg::*;
#(
  parameter logic [BCD_W-1:0] MAX = 4'd9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ld,
  input  logic [BCD_W-1:0] ld_val,
  output logic [BCD_W-1:0] q,
  output logic             borrow
);

  // digit register: load wins over count
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (ld) begin
      q <= ld_val;
    end else if (en) begin
      q <= (q == '0) ? MAX : q - 1'b1;
    end
  end

  // borrow out when this digit wraps
  always_comb begin
    borrow = en && (q == '0);
  end

endmodule

// File: rtl/mmss_countdown_timer.sv
// MM:SS countdown timer: prescaler, control FSM,
// load validation, reload register and expiry detect.
module mmss_countdown_timer
  import mmss_countdown_timer_pkg::*;
#(
  parameter int TICK_DIV     = 50_000_000,
  parameter int RELOAD_MODE  = 0,
  parameter int MAX_MIN_TENS = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        start,
  input  logic        pause,
  output logic [3:0]  sec_unit,
  output logic [3:0]  sec_tens,
  output logic [3:0]  min_unit,
  output logic [3:0]  min_tens,
  output logic        running,
  output logic        finished,
  output logic        done,
  output logic        load_err
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] P_TOP = PW'(TICK_DIV - 1);
  localparam logic [3:0] MT_MAX = 4'(MAX_MIN_TENS);

  state_t state, state_nx;

  logic [PW-1:0] presc;
  logic [15:0]   reload_reg;
  logic [15:0]   value;
  logic [15:0]   digit_val;
  logic [3:0]    bor;

  logic ld_ok, ld_good, ld_bad;
  logic tick, step, at_one, expire;
  logic start_ok, go_run, restart;
  logic digit_ld;
  logic fin_q, err_q;

  // decode of the current cycle's requests
  always_comb begin
    value    = {min_tens, min_unit, sec_tens, sec_unit};
    ld_ok    = (load_val[3:0]   <= DIGIT_MAX)
            && (load_val[7:4]   <= SEC_TENS_MAX)
            && (load_val[11:8]  <= DIGIT_MAX)
            && (load_val[15:12] <= MT_MAX);
    ld_good  = load && ld_ok;
    ld_bad   = load && !ld_ok;
    tick     = (state == ST_RUN) && (presc == P_TOP);
    step     = tick && !load && !pause;
    at_one   = (value == 16'h0001);
    expire   = step && at_one;
    start_ok = start && !load;
    go_run   = start_ok && (state == ST_IDLE)
            && (value != 16'h0000);
    restart  = start_ok && (state == ST_DONE)
            && (reload_reg != 16'h0000);
    // bor[3] only fires on an underflow from 00:00;
    // reload rather than show a wrapped value
    digit_ld = ld_good || restart || bor[3]
            || (expire && (RELOAD_MODE != 0));
    digit_val = ld_good ? load_val : reload_reg;
  end

  bcd_down_digit #(.MAX(DIGIT_MAX)) u_su (
    .clk    (clk),
    .rst    (rst),
    .en     (step),
    .ld     (digit_ld),
    .ld_val (digit_val[3:0]),
    .q      (sec_unit),
    .borrow (bor[0])
  );

  bcd_down_digit #(.MAX(SEC_TENS_MAX)) u_st (
    .clk    (clk),
    .rst    (rst),
    .en     (bor[0]),
    .ld     (digit_ld),
    .ld_val (digit_val[7:4]),
    .q      (sec_tens),
    .borrow (bor[1])
  );

  bcd_down_digit #(.MAX(DIGIT_MAX)) u_mu (
    .clk    (clk),
    .rst    (rst),
    .en     (bor[1]),
    .ld     (digit_ld),
    .ld_val (digit_val[11:8]),
    .q      (min_unit),
    .borrow (bor[2])
  );

  bcd_down_digit #(.MAX(MT_MAX)) u_mt (
    .clk    (clk),
    .rst    (rst),
    .en     (bor[2]),
    .ld     (digit_ld),
    .ld_val (digit_val[15:12]),
    .q      (min_tens),
    .borrow (bor[3])
  );

  // seconds prescaler; holds while paused or on a rejected load
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
    end else if (ld_good || go_run || restart) begin
      presc <= '0;
    end else if (state == ST_RUN && !load && !pause) begin
      presc <= tick ? '0 : presc + 1'b1;
    end
  end

  // reload value and registered pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      reload_reg <= '0;
      fin_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (ld_good) begin
        reload_reg <= load_val;
      end
      fin_q <= expire;
      err_q <= ld_bad;
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    if (ld_good) begin
      state_nx = ST_IDLE;
    end else if (!load) begin
      unique case (state)
        ST_IDLE: begin
          if (go_run) state_nx = ST_RUN;
        end
        ST_RUN: begin
          if (pause) begin
            state_nx = ST_PAUSE;
          end else if (expire && RELOAD_MODE == 0) begin
            state_nx = ST_DONE;
          end
        end
        ST_PAUSE: begin
          if (start) state_nx = ST_RUN;
        end
        ST_DONE: begin
          if (restart) state_nx = ST_RUN;
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // status outputs, all from registers
  always_comb begin
    running  = (state == ST_RUN);
    done     = (state == ST_DONE);
    finished = fin_q;
    load_err = err_q;
  end

endmodule

// File: tb/tb_mmss_countdown_timer.sv
// Bench for mmss_countdown_timer: one-shot and auto-reload
// instances share stimulus, checked against a seconds-based model.
module tb_mmss_countdown_timer;

  localparam int TD = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic load = 1'b0;
  logic start = 1'b0;
  logic pause = 1'b0;
  logic [15:0] load_val = '0;

  logic [3:0] su0, st0, mu0, mt0, su1, st1, mu1, mt1;
  logic run0, fin0, dn0, err0, run1, fin1, dn1, err1;
  logic [15:0] dig0, dig1;

  assign dig0 = {mt0, mu0, st0, su0};
  assign dig1 = {mt1, mu1, st1, su1};

  always #5 clk = ~clk;

  mmss_countdown_timer #(
    .TICK_DIV(TD), .RELOAD_MODE(0), .MAX_MIN_TENS(5)
  ) dut0 (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val),
    .start(start), .pause(pause),
    .sec_unit(su0), .sec_tens(st0),
    .min_unit(mu0), .min_tens(mt0),
    .running(run0), .finished(fin0),
    .done(dn0), .load_err(err0)
  );

  mmss_countdown_timer #(
    .TICK_DIV(TD), .RELOAD_MODE(1), .MAX_MIN_TENS(5)
  ) dut1 (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val),
    .start(start), .pause(pause),
    .sec_unit(su1), .sec_tens(st1),
    .min_unit(mu1), .min_tens(mt1),
    .running(run1), .finished(fin1),
    .done(dn1), .load_err(err1)
  );

  typedef struct {
    logic [15:0] dig;
    logic        run;
    logic        fin;
    logic        dn;
    logic        err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int n_tests = 0;
  int n_fail = 0;

  task automatic check(string name, logic [15:0] act,
                       logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h t=%0t",
               name, act, exp, $time);
    end
  endtask

  // reference model: value held as plain seconds
  int m_secs[2];
  int m_rel[2];
  int m_pre[2];
  int m_st[2];  // 0 idle, 1 run, 2 pause, 3 done

  function automatic bit bcd_ok(logic [15:0] v);
    return v[3:0] <= 9 && v[7:4] <= 5
        && v[11:8] <= 9 && v[15:12] <= 5;
  endfunction

  function automatic int bcd2s(logic [15:0] v);
    return int'(v[15:12]) * 600 + int'(v[11:8]) * 60
         + int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [15:0] s2bcd(int s);
    int m;
    int x;
    m = s / 60;
    x = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction

  task automatic model(int md, bit r, bit ld, logic [15:0] lv,
                       bit sb, bit pb, output exp_t e);
    bit f;
    bit er;
    f = 0;
    er = 0;
    if (r) begin
      m_secs[md] = 0; m_rel[md] = 0;
      m_pre[md] = 0;  m_st[md] = 0;
    end else if (ld) begin
      if (bcd_ok(lv)) begin
        m_secs[md] = bcd2s(lv);
        m_rel[md] = m_secs[md];
        m_pre[md] = 0;
        m_st[md] = 0;
      end else begin
        er = 1;
      end
    end else begin
      case (m_st[md])
        0: if (sb && m_secs[md] != 0) begin
          m_st[md] = 1;
          m_pre[md] = 0;
        end
        1: if (pb) begin
          m_st[md] = 2;
        end else if (m_pre[md] == TD - 1) begin
          m_pre[md] = 0;
          if (m_secs[md] == 1) begin
            f = 1;
            if (md == 1) m_secs[md] = m_rel[md];
            else begin
              m_secs[md] = 0;
              m_st[md] = 3;
            end
          end else begin
            m_secs[md] = m_secs[md] - 1;
          end
        end else begin
          m_pre[md] = m_pre[md] + 1;
        end
        2: if (sb) m_st[md] = 1;
        default: if (sb && m_rel[md] != 0) begin
          m_secs[md] = m_rel[md];
          m_pre[md] = 0;
          m_st[md] = 1;
        end
      endcase
    end
    e.dig = s2bcd(m_secs[md]);
    e.run = (m_st[md] == 1);
    e.dn  = (m_st[md] == 3);
    e.fin = f;
    e.err = er;
  endtask

  // drive one cycle and queue the expected post-edge outputs
  task automatic step(bit r, bit ld, logic [15:0] lv,
                      bit sb, bit pb);
    exp_t e;
    @(negedge clk);
    rst = r; load = ld; load_val = lv;
    start = sb; pause = pb;
    model(0, r, ld, lv, sb, pb, e);
    q0.push_back(e);
    model(1, r, ld, lv, sb, pb, e);
    q1.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic idle(int n);
    repeat (n) step(0, 0, 16'h0, 0, 0);
  endtask

  // monitor: compare every DUT output against the queue
  initial begin
    exp_t e0;
    exp_t e1;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0 && q1.size() > 0) begin
        e0 = q0.pop_front();
        e1 = q1.pop_front();
        check("sb0_digits", dig0, e0.dig);
        check("sb0_running", 16'(run0), 16'(e0.run));
        check("sb0_finished", 16'(fin0), 16'(e0.fin));
        check("sb0_done", 16'(dn0), 16'(e0.dn));
        check("sb0_load_err", 16'(err0), 16'(e0.err));
        check("sb1_digits", dig1, e1.dig);
        check("sb1_running", 16'(run1), 16'(e1.run));
        check("sb1_finished", 16'(fin1), 16'(e1.fin));
        check("sb1_done", 16'(dn1), 16'(e1.dn));
        check("sb1_load_err", 16'(err1), 16'(e1.err));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  int exp5[6] = '{2, 1, 3, 2, 1, 3};

  initial begin
    logic [15:0] lv;
    int r;
    int k;

    // reset state
    step(1, 0, 16'h0, 0, 0);
    check("rst_digits", dig0, 16'h0000);
    check("rst_flags", {12'h0, run0, fin0, dn0, err0}, 16'h0);

    // cascaded borrow
    step(0, 1, 16'h0102, 0, 0);
    step(0, 0, 16'h0, 1, 0);
    idle(4);
    check("t1_0101", dig0, 16'h0101);
    check("t1_running", 16'(run0), 16'h1);
    idle(4);
    check("t1_0100", dig0, 16'h0100);
    idle(4);
    check("t1_0059", dig0, 16'h0059);
    check("t1_running_end", 16'(run0), 16'h1);

    // one-shot expiry and restart
    step(0, 1, 16'h0002, 0, 0);
    step(0, 0, 16'h0, 1, 0);
    idle(7);
    check("t2_0001", dig0, 16'h0001);
    check("t2_no_fin_early", 16'(fin0), 16'h0);
    idle(1);
    check("t2_0000", dig0, 16'h0000);
    check("t2_fin", 16'(fin0), 16'h1);
    check("t2_done", 16'(dn0), 16'h1);
    check("t2_not_running", 16'(run0), 16'h0);
    check("t2_reload_digits", dig1, 16'h0002);
    check("t2_reload_fin", 16'(fin1), 16'h1);
    idle(1);
    check("t2_fin_one_cycle", 16'(fin0), 16'h0);
    step(0, 0, 16'h0, 1, 0);
    check("t2_restart", dig0, 16'h0002);
    check("t2_restart_run", 16'(run0), 16'h1);

    // rejected load
    step(0, 1, 16'h0045, 0, 0);
    step(0, 1, 16'h0070, 0, 0);
    check("t3_err", 16'(err0), 16'h1);
    check("t3_hold", dig0, 16'h0045);
    check("t3_idle", 16'(run0), 16'h0);
    idle(1);
    check("t3_err_pulse", 16'(err0), 16'h0);
    step(0, 1, 16'h0030, 0, 0);
    check("t3_accept", dig0, 16'h0030);

    // pause / resume, then pause on a tick
    step(0, 0, 16'h0, 1, 0);
    idle(2);
    step(0, 0, 16'h0, 0, 1);
    idle(10);
    check("t4_frozen", dig0, 16'h0030);
    check("t4_paused", 16'(run0), 16'h0);
    step(0, 0, 16'h0, 1, 0);
    idle(1);
    check("t4_no_tick_yet", dig0, 16'h0030);
    idle(1);
    check("t4_tick", dig0, 16'h0029);
    idle(3);
    step(0, 0, 16'h0, 0, 1);
    check("t4_tick_suppressed", dig0, 16'h0029);
    step(0, 0, 16'h0, 1, 0);
    idle(1);
    check("t4_resume_tick", dig0, 16'h0028);

    // auto-reload period
    step(0, 1, 16'h0003, 0, 0);
    step(0, 0, 16'h0, 1, 0);
    for (int i = 0; i < 6; i++) begin
      idle(4);
      check("t5_digits", dig1, 16'(exp5[i]));
      check("t5_fin", 16'(fin1), 16'(exp5[i] == 3));
      check("t5_done", 16'(dn1), 16'h0);
    end

    // reset mid-run
    step(0, 1, 16'h0041, 0, 0);
    step(0, 0, 16'h0, 1, 0);
    idle(3);
    step(1, 0, 16'h0, 0, 0);
    check("t6_digits", dig0, 16'h0000);
    check("t6_flags", {12'h0, run0, fin0, dn0, err0}, 16'h0);
    step(0, 0, 16'h0, 1, 0);
    check("t6_start_ignored", 16'(run0), 16'h0);

    // randomized traffic
    for (int n = 0; n < 2500; n++) begin
      r = $urandom_range(0, 99);
      if (r < 1) begin
        step(1, 0, 16'h0, 0, 0);
      end else if (r < 6) begin
        if ($urandom_range(0, 1) == 1)
          lv = s2bcd($urandom_range(0, 20));
        else
          lv = s2bcd($urandom_range(0, 3599));
        step(0, 1, lv, 0, 0);
      end else if (r < 8) begin
        lv = s2bcd($urandom_range(0, 3599));
        k = $urandom_range(0, 3);
        case (k)
          0: lv[3:0]   = 4'($urandom_range(10, 15));
          1: lv[7:4]   = 4'($urandom_range(6, 15));
          2: lv[11:8]  = 4'($urandom_range(10, 15));
          default: lv[15:12] = 4'($urandom_range(6, 15));
        endcase
        step(0, 1, lv, 0, 0);
      end else if (r < 14) begin
        step(0, 0, 16'h0, 0, 1);
      end else if (r < 30) begin
        step(0, 0, 16'h0, 1, 0);
      end else begin
        idle(1);
      end
    end

    idle(1);
    check("sb_drained", 16'(q0.size()), 16'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
